// File: rtl/contador_descendente.sv
// Loadable down-counter with IDLE/RUN/HOLD control, terminal-count pulse and busy flag.
// Define AUTORELOAD_EN to reload the counter from the last loaded value at terminal count.
module contador_descendente #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q,  busy_d;
  logic             tc_q,    tc_d;
`ifdef AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state, next-count and output computation; load overrides the FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = din;
`ifdef AUTORELOAD_EN
      reload_d = din;
`endif
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (count_q != CNT_ZERO)) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (count_q == CNT_ONE) begin
            tc_d = 1'b1;
`ifdef AUTORELOAD_EN
            count_d = reload_q;
            state_d = RUN;
`else
            count_d = CNT_ZERO;
            state_d = IDLE;
`endif
          end else if (count_q == CNT_ZERO) begin
            // Unreachable in normal operation; never wrap below zero
            state_d = IDLE;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        HOLD: begin
          if (pause) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= CNT_ZERO;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef AUTORELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
`ifdef AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_contador_descendente.sv
// Self-checking bench for contador_descendente: vector table plus directed
// multi-cycle sequences, expectations queued at drive time and compared after the edge.
module tb_contador_descendente;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       start;
    logic       pause;
    logic [7:0] e_count;
    logic       e_busy;
    logic       e_tc;
  } vec_t;

  typedef struct {
    logic [7:0] count;
    logic       busy;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       tc;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  contador_descendente #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .start(start),
    .pause(pause),
    .count(count),
    .busy (busy),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic l, logic [7:0] d, logic s, logic p,
                              logic [7:0] ec, logic eb, logic et);
    vec_t v;
    v.rst = r; v.load = l; v.din = d; v.start = s; v.pause = p;
    v.e_count = ec; v.e_busy = eb; v.e_tc = et;
    return v;
  endfunction

  task automatic check_bit(string name, logic act, logic req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
  endtask

  // Drive one vector, queue its expectation, then compare after the edge
  task automatic apply(string name, vec_t v);
    exp_t e;
    rst = v.rst; load = v.load; din = v.din; start = v.start; pause = v.pause;
    e.count = v.e_count; e.busy = v.e_busy; e.tc = v.e_tc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      n_total++;
      if (count === e.count) n_pass++;
      else $display("FAIL %s.count: got %0d, expected %0d at %0t", name, count, e.count, $time);
      check_bit({name, ".busy"}, busy, e.busy);
      check_bit({name, ".tc"}, tc, e.tc);
    end
  endtask

  initial begin
    // Reset dominates load
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    // Load 0 then start: ignored
    vecs.push_back(mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    // Pause in IDLE does nothing
    vecs.push_back(mk(1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0));
`ifndef AUTORELOAD_EN
    // Load 3, start: 3,3,2,1,0 with tc/busy-drop on 0
    vecs.push_back(mk(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    // Load 5, start, pause at 3 (start ignored in RUN/HOLD)
    vecs.push_back(mk(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
`else
    // Load 2, start: 2,2,1,2,1,2 with tc on every reload
    vecs.push_back(mk(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
`endif

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Load mid-countdown from 200 aborts to IDLE
    apply("ld200", mk(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 8'd200, 1'b0, 1'b0));
    apply("st200", mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd200, 1'b1, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      apply("run200", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'(200 - k), 1'b1, 1'b0));
    end
    apply("reld2", mk(1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0));
    apply("idle2", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0));

    // Reset in the middle of a pause
    apply("ld4", mk(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0));
    apply("st4", mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0));
    apply("hold4", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0));
    apply("rsthold", mk(1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0));
    apply("afterrst", mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));

    // Full-range countdown from 255
    apply("ldff", mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0));
    apply("stff", mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0));
    for (int k = 254; k >= 1; k--) begin
      apply("runff", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'(k), 1'b1, 1'b0));
    end
`ifndef AUTORELOAD_EN
    apply("tcff", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
    apply("postff", mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));
`else
    apply("tcff", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b1));
    apply("postff", mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd254, 1'b1, 1'b0));
    apply("ldstop", mk(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/contador_descendente.md
CONTADOR_DESCENDENTE -- requirements
Module: contador_descendente

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the counter and load-data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: when high, capture din into count and the reload register.
REQ-005 The block SHALL have port din, input, WIDTH bits: the load value.
REQ-006 The block SHALL have port start, input, 1 bit: begins countdown from IDLE.
REQ-007 The block SHALL have port pause, input, 1 bit: level-sensitive freeze of a running countdown.
REQ-008 The block SHALL have port count, output, WIDTH bits: the registered current count value.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse, one cycle wide.

Function
REQ-011 The block SHALL implement an FSM with the states IDLE, RUN and HOLD.
REQ-012 Input priority per cycle SHALL be rst > load > start > pause.
REQ-013 Load:
- In any state, count <= din and reload <= din.
- The state goes to IDLE and tc <= 0 on the next edge.
REQ-014 IDLE:
- start=1 with count!=0 -> RUN; count is unchanged that cycle.
- start=1 with count==0 -> ignored; the state stays IDLE and tc stays 0.
REQ-015 RUN, pause=0:
- count <= count-1 every cycle.
- pause=1 -> HOLD; count is held that cycle.
REQ-016 HOLD:
- count is held.
- pause=0 -> RUN; decrementing resumes on the following cycle.
- start is ignored.
REQ-017 Terminal count, decrement from 1:
- count <= 0 and tc <= 1 for exactly one cycle, aligned with count reaching its post-terminal value.
- Next state IDLE (see REQ-022).
REQ-018 start in RUN or HOLD SHALL have no effect.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH, but count SHALL never decrement below 0 because RUN always exits at terminal.
REQ-020 busy SHALL be registered, consistent with the state in the same cycle, and drop in the cycle tc is asserted (non-reload mode).

Reset
REQ-021 rst=1 at a clock edge SHALL set:
- count=0, reload=0, state=IDLE, busy=0, tc=0.
- This overrides load, start and pause, including mid-countdown and mid-pause.

Configuration
REQ-022 Macro AUTORELOAD_EN:
- Defined: at terminal count (decrement from 1), count <= reload, tc <= 1 for one cycle, the state stays RUN and busy stays 1; the cycle repeats until load or rst.
- Undefined: REQ-017 behaviour applies (count <= 0, state IDLE); the reload register is not needed for counting.
- Pause and load behave identically in both builds.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- rst=1 for 2 cycles while load=1, din=8'h55 -> count=0, busy=0, tc=0 after release.
- load din=3, then start 1 cycle -> count sequence 3,3,2,1,0; tc=1 only in the cycle count=0; busy 1->0 in that same cycle (macro undefined).
- load din=5, start, pause=1 for 3 cycles after count=3 -> count holds 3 for 3 cycles, busy=1, then resumes 2,1,0.
- load din=0, start -> stays IDLE, count=0, busy=0, tc never asserts.
- load din=2 mid-countdown from 200 -> next cycle count=2, state IDLE, busy=0, tc=0.
- With AUTORELOAD_EN: load din=2, start -> count 2,2,1,2,1,2..., tc pulses every 2 cycles, busy stays 1; rst mid-run returns count=0, busy=0.
